dmem_wait_ctrl: RTL and testbench
=================================

DMEM_WAIT_CTRL -- requirements
Module: dmem_wait_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit data-memory words (power of two).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the access wait states (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port mem_read, input, 1 bit: load request from the datapath control.
REQ-006 The block SHALL have port mem_write, input, 1 bit: store request from the datapath control.
REQ-007 The block SHALL have port addr, input, 32 bits: byte address, equal to the datapath alu_result.
REQ-008 The block SHALL have port write_data, input, 32 bits: store data, equal to the datapath write_data.
REQ-009 The block SHALL have port read_data, output, 32 bits: load data returned to the datapath read_data.
REQ-010 The block SHALL have port stall, output, 1 bit: freezes the PC and register-file write while high.
REQ-011 The block SHALL have port misalign_err, output, 1 bit: sticky misaligned-access flag.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-013 IDLE SHALL hold while neither mem_read nor mem_write is high.
REQ-014 IDLE with a request SHALL latch addr, write_data and the operation, load the wait counter with WAIT_CYCLES-1 and move to BUSY.
REQ-015 BUSY SHALL decrement the counter each cycle; at counter 0 the access SHALL execute on that edge and the FSM SHALL move to DONE.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE; the still-asserted request in DONE SHALL NOT start a new access.
REQ-017 stall SHALL be combinational: high when (IDLE and a request) or BUSY; low in DONE and in idle IDLE.
REQ-018 A memory instruction SHALL therefore occupy WAIT_CYCLES+2 cycles; a non-memory instruction SHALL add 0 cycles.
REQ-019 A load SHALL register mem[index] into read_data on the BUSY-to-DONE edge; read_data SHALL then hold until the next load completes.
REQ-020 A store SHALL write the latched data on the BUSY-to-DONE edge; read_data SHALL be unchanged by a store.
REQ-021 When mem_read and mem_write are both high, the access SHALL be a store.
REQ-022 The word index SHALL be latched addr[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-023 The request inputs SHALL be sampled only in IDLE; changes to them during BUSY SHALL have no effect.

Reset
REQ-024 rst SHALL asynchronously force state IDLE, counter 0, read_data 0, misalign_err 0 and stall 0 (stall combinational, given no request is pending).
REQ-025 A reset during BUSY SHALL cancel the pending store, leaving memory unchanged.
REQ-026 Memory array contents SHALL NOT be reset.

Configuration
REQ-027 With macro DMEM_MISALIGN_TRAP_EN defined, a request with addr[1:0]!=0 in IDLE SHALL NOT access memory, SHALL NOT stall, and SHALL set misalign_err until reset.
REQ-028 Without DMEM_MISALIGN_TRAP_EN, addr[1:0] SHALL be ignored and misalign_err SHALL be tied to 0.

Structure
REQ-029 Package dmem_pkg SHALL hold the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), DEPTH_WORDS/WAIT_CYCLES defaults and the counter width (4).
REQ-030 Sub-module dmem_array SHALL hold the storage: synchronous write enable and registered read, with no reset.

Verification
REQ-031 After reset, a store 0xDEADBEEF to 0x10 followed by a load from 0x10 SHALL return read_data=0xDEADBEEF; each access SHALL show stall high for exactly 3 cycles (WAIT_CYCLES=2).
REQ-032 With DEPTH_WORDS=256, a store 0x12345678 to 0x400 SHALL be read back by a load from 0x000 (wrap).
REQ-033 With mem_read=mem_write=1, addr 0x20 and data 0x55 SHALL perform a store; read_data SHALL be unchanged.
REQ-034 rst pulsed in the second BUSY cycle of a store 0xAAAA to 0x8 SHALL yield IDLE, stall=0, and a later load from 0x8 SHALL return the prior value.
REQ-035 With DMEM_MISALIGN_TRAP_EN, a load from 0x6 SHALL give stall=0 and misalign_err=1 that persists through later aligned accesses until rst.
REQ-036 Back-to-back loads from 0x0 and 0x4, with the request held through DONE, SHALL produce exactly two accesses with no extra stall cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-stated data-memory controller:
// FSM state encoding, default geometry/timing and the wait counter width.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_DEPTH_WORDS = 256;
   localparam int DEFAULT_WAIT_CYCLES = 2;
   localparam int CNT_W               = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-wide data storage: synchronous write, registered read with enable.
// Contents and the read register are deliberately not reset.
module dmem_array #(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [IDX_W-1:0]  idx,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Write port and registered read port share one index; read holds until re.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      if (re) begin
         rdata_q <= mem[idx];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data-memory controller that inserts WAIT_CYCLES wait states per access and
// stalls the datapath meanwhile (IDLE -> BUSY -> DONE -> IDLE).
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned requests are
// dropped without stalling and raise the sticky misalign_err flag).
module dmem_wait_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        stall,
   output logic        misalign_err
);

   localparam int               IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             is_store_q, is_store_d;
   logic             rd_valid_q, rd_valid_d;

   logic             req;
   logic             misaligned;
   logic             start;
   logic             mem_we;
   logic             mem_re;
   logic [31:0]      arr_rdata;

   // Upper address bits only select aliases of the same word.
   logic             unused_addr_bits;
   assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};

   assign req   = mem_read | mem_write;
   assign start = req & ~misaligned;

`ifdef DMEM_MISALIGN_TRAP_EN
   logic misalign_err_q, misalign_err_d;

   assign misaligned = (addr[1:0] != 2'b00);

   // Sticky flag: any misaligned request seen in IDLE sets it until reset.
   always_comb begin
      misalign_err_d = misalign_err_q;
      if ((state_q == IDLE) && req && misaligned) begin
         misalign_err_d = 1'b1;
      end
   end

   // Flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_err_q <= 1'b0;
      end else begin
         misalign_err_q <= misalign_err_d;
      end
   end

   assign misalign_err = misalign_err_q;
`else
   assign misaligned   = 1'b0;
   assign misalign_err = 1'b0;
`endif

   // Next-state logic: capture the request in IDLE, count down in BUSY.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      is_store_d = is_store_q;
      rd_valid_d = rd_valid_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = BUSY;
               cnt_d      = CNT_LOAD;
               idx_d      = addr[IDX_W+1:2];
               wdata_d    = write_data;
               is_store_d = mem_write;   // store wins when both are high
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = DONE;
               if (!is_store_q) begin
                  rd_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;           // request still high here is ignored
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: stall and the single-cycle memory strobes on the final BUSY edge.
   always_comb begin
      stall  = 1'b0;
      mem_we = 1'b0;
      mem_re = 1'b0;
      case (state_q)
         IDLE: begin
            stall = start;
         end
         BUSY: begin
            stall = 1'b1;
            if (cnt_q == '0) begin
               mem_we = is_store_q;
               mem_re = ~is_store_q;
            end
         end
         default: begin
            stall = 1'b0;
         end
      endcase
   end

   // State and captured-request registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         wdata_q    <= '0;
         is_store_q <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         is_store_q <= is_store_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   // The array read register is not reset, so mask it until a load completes.
   assign read_data = rd_valid_q ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed bench for dmem_wait_ctrl (DEPTH_WORDS=256, WAIT_CYCLES=2).
module tb_dmem_wait_ctrl;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        glitch;     // corrupt request inputs during BUSY
      logic        hold;       // go straight into the next access
      logic [31:0] exp_rdata;  // read_data expected in DONE
      int          exp_stall;  // stall-high cycles expected
   } vec_t;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        stall;
   logic        misalign_err;

   int   n_tests;
   int   n_fail;
   logic exp_mis;
   vec_t vecs [14];

   dmem_wait_ctrl #(
      .DEPTH_WORDS (256),
      .WAIT_CYCLES (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .addr         (addr),
      .write_data   (write_data),
      .read_data    (read_data),
      .stall        (stall),
      .misalign_err (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts at posedge+1, returns at posedge+1 with the controller in IDLE.
   task automatic run_vec(input int id, input vec_t v);
      int cyc;
      bit done;
      mem_read   = v.rd;
      mem_write  = v.wr;
      addr       = v.addr;
      write_data = v.wdata;
      cyc  = 0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (stall) begin
            cyc++;
            if (v.glitch && cyc == 2) begin
               mem_read   = 1'b1;
               mem_write  = ~v.wr;
               addr       = 32'h10;
               write_data = 32'h0;
            end
         end else begin
            done = 1'b1;
         end
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL vec%0d timeout: stall still high after %0d cycles, required low", id, cyc);
      end
      check32($sformatf("vec%0d stall_cycles", id), cyc, v.exp_stall);
      check32($sformatf("vec%0d read_data", id), read_data, v.exp_rdata);
      check32($sformatf("vec%0d misalign_err", id), {31'b0, misalign_err}, {31'b0, exp_mis});
      $display("[TB] vec %0d rd=%0b wr=%0b addr=%h wdata=%h stall_cycles=%0d read_data=%h",
               id, v.rd, v.wr, v.addr, v.wdata, cyc, read_data);
      @(posedge clk); #1;
      if (!v.hold) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
         @(negedge clk);
         check32($sformatf("vec%0d idle_stall", id), {31'b0, stall}, 32'h0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      n_tests = 0;
      n_fail  = 0;
      exp_mis = 1'b0;

      //           rd    wr    addr          wdata         glitch hold  exp_rdata     stall
      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0000_0000, 3};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 3};
      vecs[2]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h12345678, 1'b0, 1'b0, 32'hDEADBEEF, 3};
      vecs[3]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0, 32'h12345678, 3};
      vecs[4]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055, 1'b0, 1'b0, 32'h12345678, 3};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        1'b0, 1'b0, 32'h0000_0055, 3};
      vecs[6]  = '{1'b0, 1'b1, 32'h0000_0004, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0000_0055, 3};
      vecs[7]  = '{1'b0, 1'b1, 32'h0000_000C, 32'h0BADF00D, 1'b1, 1'b0, 32'h0000_0055, 3};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,        1'b1, 1'b0, 32'h0BADF00D, 3};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 3};
      vecs[10] = '{1'b0, 1'b1, 32'h0000_0008, 32'h0000_1111, 1'b0, 1'b0, 32'hDEADBEEF, 3};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b1, 32'h12345678, 3};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D, 3};
      vecs[13] = '{1'b1, 1'b0, 32'h1000_0010, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 3};

      rst        = 1'b1;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      addr       = 32'h0;
      write_data = 32'h0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check32("reset stall", {31'b0, stall}, 32'h0);
      check32("reset read_data", read_data, 32'h0);
      check32("reset misalign_err", {31'b0, misalign_err}, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         run_vec(i, vecs[i]);
      end

      // Reset in the second BUSY cycle of a store cancels it.
      mem_write  = 1'b1;
      addr       = 32'h8;
      write_data = 32'h0000_AAAA;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst       = 1'b1;
      mem_write = 1'b0;
      #1;
      check32("busy_rst stall", {31'b0, stall}, 32'h0);
      check32("busy_rst read_data", read_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check32("busy_rst idle_stall", {31'b0, stall}, 32'h0);
      $display("[TB] reset during BUSY store addr=00000008 wdata=0000aaaa");
      @(posedge clk); #1;
      v = '{1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0000_1111, 3};
      run_vec(14, v);

`ifdef DMEM_MISALIGN_TRAP_EN
      mem_read = 1'b1;
      addr     = 32'h6;
      @(negedge clk);
      check32("mis stall", {31'b0, stall}, 32'h0);
      check32("mis flag", {31'b0, misalign_err}, 32'h1);
      $display("[TB] misaligned load addr=00000006 stall=%0b misalign_err=%0b", stall, misalign_err);
      @(posedge clk); #1;
      mem_read = 1'b0;
      @(negedge clk);
      check32("mis flag sticky", {31'b0, misalign_err}, 32'h1);
      @(posedge clk); #1;
      exp_mis = 1'b1;
      v = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 3};
      run_vec(15, v);
      rst = 1'b1;
      #1;
      check32("mis flag reset", {31'b0, misalign_err}, 32'h0);
      exp_mis = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
`else
      v = '{1'b1, 1'b0, 32'h6, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, 3};
      run_vec(15, v);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
